// File: rtl/mvm_pkg.sv
// Shared defaults, typedefs and index-width helpers for the MVM datapath.
package mvm_pkg;

   localparam int MVM_N    = 8;
   localparam int MVM_M    = 8;
   localparam int MVM_DW   = 8;
   localparam int MVM_ACCW = 2*MVM_DW + $clog2(MVM_N);
   localparam int MVM_NS   = $clog2(MVM_N) + 1;
   localparam int MVM_IW   = (MVM_N > 1) ? $clog2(MVM_N) : 1;

   typedef logic signed [MVM_DW-1:0]   mvm_data_t;
   typedef logic signed [2*MVM_DW-1:0] mvm_prod_t;
   typedef logic signed [MVM_ACCW-1:0] mvm_acc_t;

   // Row-index width that stays legal for a single-row array.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mvm_mac_lane.sv
// One output column: registered signed product and wrapping accumulator.
module mvm_mac_lane #(
   parameter int DW   = 8,
   parameter int ACCW = 19
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   calc,
   input  logic                   up_sum,
   input  logic                   clr,
   input  logic signed [DW-1:0]   x,
   input  logic signed [DW-1:0]   w,
   output logic signed [ACCW-1:0] acc
);

   logic signed [2*DW-1:0] prod_q, prod_d;
   logic signed [ACCW-1:0] acc_q, acc_d;

   always_comb begin
      prod_d = prod_q;
      if (calc) prod_d = (2*DW)'(x) * (2*DW)'(w);
      // Clear wins over accumulate if both strobes coincide.
      acc_d = acc_q;
      if (clr)         acc_d = '0;
      else if (up_sum) acc_d = acc_q + ACCW'(prod_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prod_q <= '0;
         acc_q  <= '0;
      end else begin
         prod_q <= prod_d;
         acc_q  <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/mvm_dp_unit.sv
// MVM datapath responder: weight RAM, input vector, M MAC lanes, result capture.
// Zero-input skip hint is built only when MVM_DP_SKIP_EN is defined; otherwise skip is 0.
module mvm_dp_unit
   import mvm_pkg::*;
#(
   parameter int N    = MVM_N,
   parameter int M    = MVM_M,
   parameter int DW   = MVM_DW,
   parameter int NS   = $clog2(N) + 1,
   parameter int ACCW = 2*DW + $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 prog_wt,
   input  logic                 waiting,
   input  logic                 get_ready,
   input  logic                 fetch,
   input  logic                 rd_en,
   input  logic                 calc,
   input  logic                 up_sum,
   input  logic [NS-1:0]        counter,
   input  logic                 mvm_done,
   output logic                 skip,
   input  logic [$clog2(N)-1:0] wt_addr,
   input  logic [M*DW-1:0]      wt_data,
   input  logic                 in_load,
   input  logic [N*DW-1:0]      in_data,
   output logic [M*ACCW-1:0]    out_data,
   output logic                 out_valid
);

   localparam int IW = idx_width(N);

   logic [M*DW-1:0]   wt_mem [N];
   logic [N*DW-1:0]   in_q;
   logic [IW-1:0]     idx_q;
   logic [DW-1:0]     x_q;
   logic [M*DW-1:0]   w_q;
   logic [M*ACCW-1:0] acc_all;
   logic [M*ACCW-1:0] out_data_q;
   logic              out_valid_q;

   logic              cnt_in_range;
   logic [IW-1:0]     cnt_idx;
   logic [DW-1:0]     x_sel;

   assign cnt_in_range = (counter < NS'(N));
   assign cnt_idx      = counter[IW-1:0];
   assign x_sel        = in_q[cnt_idx*DW +: DW];

   // Weight storage has no reset so it survives a mid-run reset.
   always_ff @(posedge clk) begin
      if (prog_wt) wt_mem[wt_addr] <= wt_data;
   end

   // idx_q is captured at fetch because the controller has already moved counter on by rd_en.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_q        <= '0;
         idx_q       <= '0;
         x_q         <= '0;
         w_q         <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (in_load && waiting) in_q <= in_data;
         if (fetch && cnt_in_range) begin
            idx_q <= cnt_idx;
            x_q   <= x_sel;
         end
         if (rd_en)    w_q        <= wt_mem[idx_q];
         if (mvm_done) out_data_q <= acc_all;
         out_valid_q <= mvm_done;
      end
   end

   for (genvar gi = 0; gi < M; gi++) begin : g_lane
      mvm_mac_lane #(
         .DW   (DW),
         .ACCW (ACCW)
      ) u_lane (
         .clk    (clk),
         .reset  (reset),
         .calc   (calc),
         .up_sum (up_sum),
         .clr    (get_ready),
         .x      (x_q),
         .w      (w_q[gi*DW +: DW]),
         .acc    (acc_all[gi*ACCW +: ACCW])
      );
   end

`ifdef MVM_DP_SKIP_EN
   assign skip = !cnt_in_range || (x_sel == '0);
`else
   assign skip = 1'b0;
`endif

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

endmodule

// File: doc/mvm_dp_unit.md
# mvm_dp_unit

Datapath responder for the MVM control bus. Holds a programmable N×M signed weight array and an N-entry input vector. Executes the per-row fetch/read/multiply/accumulate strobes issued by the MVM control unit, and returns the `skip` hint that lets the controller bypass zero inputs. Sits beside the MVM controller inside the core; the host writes weights and inputs and collects the M accumulated outputs.

## Interface

**Parameters**
- `N`, 8: input vector length; row count of the weight array.
- `M`, 8: output vector length; column count.
- `DW`, 8: signed input/weight width.
- `NS`, `$clog2(N)+1`: counter width. Must represent the value N.
- `ACCW`, `2*DW+$clog2(N)`: signed accumulator width.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `prog_wt` in 1: controller strobe; write weight row `wt_addr`.
- `waiting` in 1: controller idle strobe; input loads are accepted only while it is high.
- `get_ready` in 1: controller strobe; clear accumulators.
- `fetch` in 1: controller strobe; latch row index and input element.
- `rd_en` in 1: controller strobe; read weight row.
- `calc` in 1: controller strobe; form the M products.
- `up_sum` in 1: controller strobe; accumulate the products.
- `counter` in NS: controller row counter.
- `mvm_done` in 1: controller completion pulse.
- `skip` out 1: current row input is zero. Combinational.
- `wt_addr` in `$clog2(N)`: weight row to write.
- `wt_data` in M*DW: weight row data; column j is at `[j*DW +: DW]`.
- `in_load` in 1: write the input vector.
- `in_data` in N*DW: input vector; element i is at `[i*DW +: DW]`.
- `out_data` out M*ACCW: result vector.
- `out_valid` out 1: one-cycle pulse when `out_data` is updated.

## Operation
- **Weights:** when `prog_wt`=1, `wt_mem[wt_addr] <= wt_data`. Weights are not reset.
- **Inputs:** when `in_load`=1 and `waiting`=1, `in_q <= in_data`. `in_load` is ignored when `waiting`=0.
- **get_ready:** `acc[0..M-1] <= 0`.
- **fetch:**
  - If `counter` < N: `idx_q <= counter`, `x_q <= in_q[counter]`.
  - `counter` ≥ N: no update.
- **rd_en:** `w_q <= wt_mem[idx_q]`.
- **calc:** `prod[j] <= x_q * w_q[j]`, signed, 2*DW wide.
- **up_sum:** `acc[j] <= acc[j] + sext(prod[j])`. Wraps at ACCW bits; no saturation.
- **mvm_done:** `out_data <= acc`, `out_valid <= 1` for one cycle.
- **skip:**
  - 1 if `counter` ≥ N, or if `in_q[counter]` == 0.
  - Otherwise 0.
- **Strobe precedence:** strobes are mutually exclusive by construction. If several are asserted, each performs its own action. `get_ready` takes precedence over `up_sum` on `acc`.
- **Reset:** clears `in_q`, `x_q`, `idx_q`, `w_q`, `prod`, `acc`, and `out_data` to 0, and `out_valid` to 0. `wt_mem` retains its contents. A reset mid-operation discards partial sums. There is no pending output after reset.

## Timing
- The controller increments `counter` in the same cycle as `fetch`. Therefore `idx_q` must be captured at `fetch`; the `counter` value during `rd_en` must not be used.
- Per non-skipped row: fetch, rd_en, calc, up_sum on four consecutive cycles. `acc` reflects the row one cycle after `up_sum`.
- A skipped row consumes one fetch cycle and leaves `acc` unchanged.
- `out_valid` asserts the cycle after `mvm_done`.
- `out_data` holds its value until the next `mvm_done` or reset.
- `skip` is purely combinational from `counter` and `in_q`, with no register stage. The controller samples it in the same cycle.

## Configuration
- **`MVM_DP_SKIP_EN` defined:** `skip` behaves as specified above.
- **`MVM_DP_SKIP_EN` not defined:**
  - `skip` is tied to 0, so every row runs through rd_en, calc and up_sum.
  - Results are numerically identical to the defined case.
  - Zero-detect logic is removed.

## Structure
- **Shared package `mvm_pkg`:**
  - Default N, M, DW, ACCW.
  - Typedefs `mvm_data_t` (signed DW), `mvm_prod_t` (signed 2*DW), `mvm_acc_t` (signed ACCW).
  - Clog2-derived index widths.
- **Sub-module `mvm_mac_lane`:** one per column, M instances. Holds `prod` and `acc`. Controls: `calc`, `up_sum`, `clr`. Inputs: `x`, `w`. Output: `acc`.
- **Top level:** `wt_mem`, `in_q`, `idx_q`, `x_q`, `w_q`, skip logic, and output capture.

## Test plan
All scenarios use N=M=4, DW=8.

1. **Identity, no skips.** Program identity weights; `in` = [1,2,3,4]; run the full strobe sequence for counter 0..3. → `out_data` = [1,2,3,4], with `out_valid` a single pulse.
2. **Skip pattern.** `in` = [0,5,0,-2]. → `skip` is 1 at counter 0 and 2, and 0 at counter 1 and 3. With all-ones weights, `out` = [3,3,3,3].
3. **Signed extremes.** All weights -128; `in` = [-128,-128,-128,-128]. → `out` = [65536 ×4], with no overflow at ACCW=18.
4. **Reset mid-run.** Assert reset after row 1's `up_sum`, then rerun scenario 1. → `acc` is cleared, `out` = [1,2,3,4], and the weights are still intact.
5. **Input-load gating.** Pulse `in_load` with `waiting`=0. → `in_q` is unchanged. Pulse `in_load` with `waiting`=1. → `in_q` is loaded.
6. **Counter guard.** `counter`=4 (=N) during `fetch`. → `skip`=1 and `idx_q`/`x_q` are unchanged. With the macro undefined, `skip`=0 throughout scenario 2 and `out` is unchanged.
